sprite_hit_decoder: RTL and testbench



---
 rtl/sprite_hit_decoder_pkg.sv | 23 ++
 rtl/sprite_hit_decoder_if.sv | 22 ++
 rtl/sprite_hit_decoder_hold_timer.sv | 43 ++++
 rtl/sprite_hit_decoder.sv | 79 +++++++
 tb/tb_sprite_hit_decoder.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sprite_hit_decoder_pkg.sv
// Shared sprite constants and types used by the hit decoder, selector and renderer.
package sprite_pkg;

    localparam int unsigned NUM_SPRITES     = 14;
    localparam int unsigned SPRITE_IDX_W    = 4;
    localparam int unsigned SPRITE_IDX_NONE = 0;
    localparam int unsigned SPRITE_IDX_MAX  = 14;

    typedef logic [NUM_SPRITES-1:0]  sprite_vec_t;
    typedef logic [SPRITE_IDX_W-1:0] sprite_idx_t;

    typedef struct packed {
        logic        valid;
        sprite_idx_t index;
    } sprite_hit_t;

    // Legal sprite numbers are 1..SPRITE_IDX_MAX; everything else is a bad index.
    function automatic logic sprite_idx_legal(input sprite_idx_t idx);
        return (idx != SPRITE_IDX_W'(SPRITE_IDX_NONE)) &&
               (idx <= SPRITE_IDX_W'(SPRITE_IDX_MAX));
    endfunction

endpackage

// File: rtl/sprite_hit_decoder_if.sv
// Hit-in / sprite-activity-out bus between hit detection, decoder and renderer.
interface sprite_hit_decoder_if;
    import sprite_pkg::*;

    logic        hit_valid;
    sprite_idx_t hit_index;
    logic        frame_tick;
    sprite_vec_t sprites;
    logic        bad_index;
    logic        busy;

    modport master (
        output hit_valid, hit_index, frame_tick,
        input  sprites, bad_index, busy
    );

    modport slave (
        input  hit_valid, hit_index, frame_tick,
        output sprites, bad_index, busy
    );

endinterface

// File: rtl/sprite_hit_decoder_hold_timer.sv
// Per-sprite frame-hold counter: loads on a hit, decays once per frame tick, saturates at 0.
module sprite_hold_timer #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    input  logic retrig_ok,
    output logic active,
    output logic active_nxt_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_idle;

    assign w_idle = (r_cnt == '0);

    // A load takes priority over the decrement on the same cycle.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load && (retrig_ok || w_idle)) begin
            w_cnt_nxt = CNT_W'(HOLD_FRAMES);
        end else if (tick && !w_idle) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    assign active_nxt_c = (w_cnt_nxt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            active <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            active <= active_nxt_c;
        end
    end

endmodule

// File: rtl/sprite_hit_decoder.sv
// Sprite index stream -> per-sprite activity vector with per-sprite frame-hold timers.
// Optional: define SPRITE_RETRIGGER_EN to let a hit on an active sprite reload its timer.
module sprite_hit_decoder
    import sprite_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_hit_decoder_if.slave bus
);

    logic        r_armed;
    logic        r_bad_index;
    logic        r_busy;
    sprite_hit_t w_hit;
    logic        w_hit_ok;
    logic        w_bad;
    logic        w_retrig_ok;
    sprite_vec_t w_load;
    sprite_vec_t w_active;
    sprite_vec_t w_active_nxt;

`ifdef SPRITE_RETRIGGER_EN
    assign w_retrig_ok = 1'b1;
`else
    assign w_retrig_ok = 1'b0;
`endif

    // Hits are blocked on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_hit.valid = bus.hit_valid;
    assign w_hit.index = bus.hit_index;
    assign w_hit_ok    = r_armed && w_hit.valid;
    assign w_bad       = w_hit_ok && !sprite_idx_legal(w_hit.index);

    genvar i;
    generate
        for (i = 0; i < NUM_SPRITES; i++) begin : g_sprite
            assign w_load[i] = w_hit_ok && (w_hit.index == SPRITE_IDX_W'(i + 1));

            sprite_hold_timer #(
                .CNT_W       (CNT_W),
                .HOLD_FRAMES (HOLD_FRAMES)
            ) u_timer (
                .clk          (clk),
                .rst_n        (rst_n),
                .load         (w_load[i]),
                .tick         (bus.frame_tick),
                .retrig_ok    (w_retrig_ok),
                .active       (w_active[i]),
                .active_nxt_c (w_active_nxt[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad_index <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_bad_index <= w_bad;
            r_busy      <= |w_active_nxt;
        end
    end

    assign bus.sprites   = w_active;
    assign bus.bad_index = r_bad_index;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sprite_hit_decoder.sv
// Directed bench for sprite_hit_decoder: vector table plus retrigger and async-reset sequences.
module tb_sprite_hit_decoder;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sprite_hit_decoder_if u_if ();

    sprite_hit_decoder #(
        .HOLD_FRAMES (8),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct {
        logic        hv;
        logic [3:0]  idx;
        logic        tick;
        logic [13:0] exp_spr;
        logic        exp_bad;
        logic        exp_busy;
    } vec_t;

    vec_t vq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic hv, input logic [3:0] idx, input logic tk);
        @(negedge clk);
        u_if.hit_valid  = hv;
        u_if.hit_index  = idx;
        u_if.frame_tick = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm, input logic [13:0] spr, input logic bad, input logic busy);
        check({nm, ".sprites"}, 32'(u_if.sprites), 32'(spr));
        check({nm, ".bad"}, 32'(u_if.bad_index), 32'(bad));
        check({nm, ".busy"}, 32'(u_if.busy), 32'(busy));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        u_if.hit_valid  = 1'b0;
        u_if.hit_index  = 4'd0;
        u_if.frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int n_more;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        u_if.hit_valid  = 1'b0;
        u_if.hit_index  = 4'd0;
        u_if.frame_tick = 1'b0;

        // Vector table: each entry is one clock of stimulus and the outputs after that edge.
        vq.push_back('{1'b1, 4'd3,  1'b0, 14'h0004, 1'b0, 1'b1});
        for (int k = 0; k < 7; k++) vq.push_back('{1'b0, 4'd0, 1'b1, 14'h0004, 1'b0, 1'b1});
        vq.push_back('{1'b0, 4'd0,  1'b1, 14'h0000, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'd0,  1'b0, 14'h0000, 1'b1, 1'b0});
        vq.push_back('{1'b0, 4'd0,  1'b0, 14'h0000, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'd15, 1'b0, 14'h0000, 1'b1, 1'b0});
        vq.push_back('{1'b0, 4'd0,  1'b0, 14'h0000, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'd1,  1'b0, 14'h0001, 1'b0, 1'b1});
        vq.push_back('{1'b1, 4'd14, 1'b0, 14'h2001, 1'b0, 1'b1});
        vq.push_back('{1'b0, 4'd5,  1'b0, 14'h2001, 1'b0, 1'b1});
        vq.push_back('{1'b1, 4'd2,  1'b0, 14'h2003, 1'b0, 1'b1});
        for (int k = 0; k < 7; k++) vq.push_back('{1'b0, 4'd0, 1'b1, 14'h2003, 1'b0, 1'b1});
        vq.push_back('{1'b1, 4'd5,  1'b1, 14'h0010, 1'b0, 1'b1});
        for (int k = 0; k < 7; k++) vq.push_back('{1'b0, 4'd0, 1'b1, 14'h0010, 1'b0, 1'b1});
        vq.push_back('{1'b0, 4'd0,  1'b1, 14'h0000, 1'b0, 1'b0});

        #12;
        check_all("reset_hold", 14'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0);
        check_all("reset_state", 14'h0000, 1'b0, 1'b0);

        foreach (vq[v]) begin
            drive(vq[v].hv, vq[v].idx, vq[v].tick);
            check_all($sformatf("vec%0d", v), vq[v].exp_spr, vq[v].exp_bad, vq[v].exp_busy);
        end

        // Retrigger sprite 7 after 5 ticks (count is 3 at the retrigger).
        do_reset();
        drive(1'b1, 4'd7, 1'b0);
        check("retrig.load", 32'(u_if.sprites), 32'h0040);
        for (int k = 0; k < 5; k++) drive(1'b0, 4'd0, 1'b1);
        check("retrig.after5", 32'(u_if.sprites), 32'h0040);
        drive(1'b1, 4'd7, 1'b0);
        check("retrig.hit", 32'(u_if.sprites), 32'h0040);
`ifdef SPRITE_RETRIGGER_EN
        n_more = 8;
`else
        n_more = 3;
`endif
        for (int k = 0; k < n_more; k++) begin
            drive(1'b0, 4'd0, 1'b1);
            check($sformatf("retrig.tick%0d", k + 1), 32'(u_if.sprites),
                  (k < n_more - 1) ? 32'h0040 : 32'h0000);
        end

        // Asynchronous reset mid-hold with four sprites active, hit during release ignored.
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b1, 4'd2, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        drive(1'b1, 4'd4, 1'b0);
        check_all("pre_reset", 14'h000F, 1'b0, 1'b1);
        drive(1'b1, 4'd0, 1'b0);
        check("pre_reset.bad", 32'(u_if.bad_index), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 14'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.hit_valid  = 1'b1;
        u_if.hit_index  = 4'd6;
        u_if.frame_tick = 1'b0;
        @(posedge clk);
        #1;
        check_all("release_hit", 14'h0000, 1'b0, 1'b0);
        drive(1'b1, 4'd6, 1'b0);
        check_all("post_release_hit", 14'h0020, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
